// File: rtl/bcd_tick_ctrl.sv
// Run/pause/clear timebase for the 3-digit BCD counter: debounced buttons, FSM, tick prescaler.
// Optional auto-stop at MAX_TICKS ticks is enabled by defining BCD_TICK_AUTO_STOP_EN.
module bcd_tick_ctrl #(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 1,
  parameter int DEB_CYCLES = 1000000,
  parameter int MAX_TICKS  = 999
) (
  input  logic CLOCK_50,
  input  logic KEY,
  input  logic btn_run_n,
  input  logic btn_clr_n,
  output logic tick,
  output logic clear,
  output logic running,
  output logic done
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int CW  = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        r_state, w_state_next;
  logic [1:0]    w_raw;
  logic [1:0]    r_sync1, r_sync2, r_deb, r_deb_q, r_press;
  logic [CW-1:0] r_cnt [2];
  logic [PW-1:0] r_presc;
  logic          r_tick, r_clear;
  logic          w_run_press, w_clr_press, w_tick_fire, w_last_tick;

  // Bit 0 is the run button, bit 1 the clear button.
  assign w_raw       = {btn_clr_n, btn_run_n};
  assign w_run_press = r_press[0];
  assign w_clr_press = r_press[1];

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_deb   <= 2'b11;
      r_deb_q <= 2'b11;
      r_press <= 2'b00;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      r_press <= r_deb_q & ~r_deb;
      // The level only moves once sync has disagreed with it for DEB_CYCLES cycles in a row.
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == DEB_LAST) begin
            r_deb[i] <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // A clear landing on the wrap cycle swallows that tick.
  assign w_tick_fire = (r_state == S_RUN) && (r_presc == PRESC_LAST) && !w_clr_press;

`ifdef BCD_TICK_AUTO_STOP_EN
  localparam int TW = $clog2(MAX_TICKS + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(MAX_TICKS - 1);
  logic [TW-1:0] r_tcnt;

  assign w_last_tick = w_tick_fire && (r_tcnt == TCNT_LAST);

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY)             r_tcnt <= '0;
    else if (w_clr_press) r_tcnt <= '0;
    else if (w_tick_fire) r_tcnt <= r_tcnt + TW'(1);
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (MAX_TICKS > 0);
  assign w_last_tick  = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_clr_press) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_run_press) w_state_next = S_RUN;
        S_RUN: begin
          if (w_last_tick)      w_state_next = S_DONE;
          else if (w_run_press) w_state_next = S_PAUSE;
        end
        S_PAUSE: if (w_run_press) w_state_next = S_RUN;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_comb begin
    running = (r_state == S_RUN);
`ifdef BCD_TICK_AUTO_STOP_EN
    done    = (r_state == S_DONE);
`else
    done    = 1'b0;
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      r_tick  <= w_tick_fire;
      r_clear <= w_clr_press;
      if (w_clr_press)
        r_presc <= '0;
      else if (r_state == S_RUN)
        r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
      else if (r_state == S_IDLE && w_run_press)
        r_presc <= '0;
    end
  end

  assign tick  = r_tick;
  assign clear = r_clear;
endmodule

// File: tb/tb_bcd_tick_ctrl.sv
// Scoreboard bench for bcd_tick_ctrl: a window-based reference model predicts the
// outputs after every clock edge and a monitor compares them on the falling edge.
module tb_bcd_tick_ctrl;
  localparam int DIV   = 10;
  localparam int DEB   = 4;
  localparam int MAX_T = 3;
`ifdef BCD_TICK_AUTO_STOP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_DONE = 3;

  logic clk = 1'b0;
  logic KEY, btn_run_n, btn_clr_n;
  logic tick, clear, running, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];

  // Reference model state: values visible after the most recent modelled edge.
  int m_st, m_run_cyc, m_tcnt;
  bit m_pv[2];
  bit m_fz[2];
  bit m_deb[2];
  bit m_r1[2], m_r2[2];
  bit m_win[2][DEB];

  bcd_tick_ctrl #(
    .CLK_HZ(100), .TICK_HZ(10), .DEB_CYCLES(DEB), .MAX_TICKS(MAX_T)
  ) dut (
    .CLOCK_50(clk), .KEY(KEY), .btn_run_n(btn_run_n), .btn_clr_n(btn_clr_n),
    .tick(tick), .clear(clear), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = ST_IDLE; m_run_cyc = 0; m_tcnt = 0;
    for (int b = 0; b < 2; b++) begin
      m_pv[b] = 0; m_fz[b] = 0; m_deb[b] = 1; m_r1[b] = 1; m_r2[b] = 1;
      for (int k = 0; k < DEB; k++) m_win[b][k] = 1;
    end
  endtask

  // Predicts {tick, clear, running, done} after the next rising edge.
  task automatic model_step(input bit rr, input bit rc, input bit key);
    bit fire, run_p, clr_p, all_diff;
    bit raw[2];
    if (!key) begin
      model_reset();
      exp_q.push_back(4'b0000);
      return;
    end
    run_p = m_pv[0];
    clr_p = m_pv[1];
    fire  = (m_st == ST_RUN) && (m_run_cyc % DIV == DIV - 1) && !clr_p;
    if (clr_p) begin
      m_st = ST_IDLE; m_run_cyc = 0; m_tcnt = 0;
    end else begin
      if (m_st == ST_RUN) m_run_cyc++;
      if (fire) m_tcnt++;
      case (m_st)
        ST_IDLE:  if (run_p) m_st = ST_RUN;
        ST_RUN: begin
          if (AUTO && fire && m_tcnt == MAX_T) m_st = ST_DONE;
          else if (run_p)                      m_st = ST_PAUSE;
        end
        ST_PAUSE: if (run_p) m_st = ST_RUN;
        default: ;
      endcase
    end
    m_pv[0] = m_fz[0];
    m_pv[1] = m_fz[1];
    raw[0] = rr;
    raw[1] = rc;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < DEB - 1; k++) m_win[b][k] = m_win[b][k+1];
      m_win[b][DEB-1] = m_r2[b];
      all_diff = 1;
      for (int k = 0; k < DEB; k++) if (m_win[b][k] == m_deb[b]) all_diff = 0;
      m_fz[b] = 0;
      if (all_diff) begin
        m_deb[b] = !m_deb[b];
        m_fz[b]  = !m_deb[b];
      end
      m_r2[b] = m_r1[b];
      m_r1[b] = raw[b];
    end
    exp_q.push_back({fire, clr_p, m_st == ST_RUN, m_st == ST_DONE});
  endtask

  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("outputs{tick,clear,running,done}", {28'd0, tick, clear, running, done}, {28'd0, e});
      chk("tick_clear_exclusive", {31'd0, tick & clear}, 32'd0);
    end
  end

  task automatic cyck(input bit rr, input bit rc, input bit key);
    @(negedge clk);
    #1;
    KEY = key; btn_run_n = rr; btn_clr_n = rc;
    model_step(rr, rc, key);
  endtask

  task automatic cyc(input bit rr, input bit rc);
    cyck(rr, rc, 1'b1);
  endtask

  task automatic hold(input bit rr, input bit rc, input int n);
    for (int i = 0; i < n; i++) cyc(rr, rc);
  endtask

  task automatic align_run(input int phase, input string name);
    bit hit = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_st == ST_RUN && m_run_cyc % DIV == phase) begin
        hit = 1;
        break;
      end
      cyc(1, 1);
    end
    chk(name, {31'd0, hit}, 32'd1);
  endtask

  initial begin
    KEY = 1'b0; btn_run_n = 1'b1; btn_clr_n = 1'b1;
    model_reset();
    #1 chk("reset_out", {28'd0, tick, clear, running, done}, 32'd0);
    for (int i = 0; i < 3; i++) cyck(1, 1, 1'b0);
    hold(1, 1, 5);

    // Bounce shorter than the window never registers.
    hold(0, 1, 3); hold(1, 1, 3); hold(0, 1, 2); hold(1, 1, 15);

    // Run start with a long hold, then steady ticks.
    hold(0, 1, 12); hold(1, 1, 40);

    // Pause with prescaler frozen at 6, then resume.
    align_run(8, "align_pause");
    hold(0, 1, 8); hold(1, 1, 50);
    hold(0, 1, 8); hold(1, 1, 40);

    // Simultaneous run and clear presses while running.
    hold(0, 0, 8); hold(1, 1, 20);

    // Clear landing on the wrap cycle suppresses the tick.
    hold(0, 1, 8); hold(1, 1, 30);
    align_run(2, "align_clear");
    hold(1, 0, 8); hold(1, 1, 20);

    // Asynchronous reset mid-run.
    hold(0, 1, 8); hold(1, 1, 25);
    @(negedge clk);
    #3 KEY = 1'b0;
    #1 chk("async_reset{tick,clear,running}", {29'd0, tick, clear, running}, 32'd0);
    model_step(1, 1, 1'b0);
    for (int i = 0; i < 3; i++) cyck(1, 1, 1'b0);
    hold(1, 1, 30);

    if (AUTO) begin
      hold(0, 1, 8); hold(1, 1, 45);
      hold(0, 1, 8); hold(1, 1, 15);
      hold(1, 0, 8); hold(1, 1, 15);
    end

    // Randomized button activity.
    for (int s = 0; s < 70; s++) begin
      int kind, hl;
      kind = $urandom_range(0, 9);
      hl   = $urandom_range(1, 14);
      if (kind <= 5)      hold(0, 1, hl);
      else if (kind <= 7) hold(1, 0, hl);
      else if (kind == 8) hold(0, 0, hl);
      hold(1, 1, $urandom_range(1, 30));
    end

    @(negedge clk);
    #2 chk("queue_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
